mul_iter: RTL

- Multi-cycle iterative radix-2 shift-add multiplier for the RV64M multiply group (MUL, MULH, MULHSU, MULHU, MULW).
- Counterpart to the combinational divide/remainder unit in the ALU: the inverse operation, sequential, with valid/ready handshakes on both sides.
- Sits beside the ALU in the execute stage. Execute holds the instruction until out_valid, then takes the result.

---
 rtl/mul_iter.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/mul_iter.sv
// mul_iter: iterative radix-2 shift-add multiplier for the RV64M multiply group (MUL/MULH/MULHSU/MULHU/MULW).
// Build option MUL_ITER_EARLY_OUT_EN: leave BUSY as soon as the remaining multiplier bits are all zero.
module mul_iter #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [3:0]      control,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result_out
);

    localparam logic [3:0] OP_MUL    = 4'd0;
    localparam logic [3:0] OP_MULH   = 4'd1;
    localparam logic [3:0] OP_MULHSU = 4'd2;
    localparam logic [3:0] OP_MULHU  = 4'd3;
    localparam logic [3:0] OP_MULW   = 4'd4;

    localparam logic [CNT_W-1:0] ITER_FULL = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] ITER_WORD = CNT_W'(XLEN / 2);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]  X_ZERO    = {XLEN{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]   acc_q;
    logic [XLEN-1:0]   mplier_q;
    logic [XLEN-1:0]   result_q;
    logic [3:0]        op_q;
    logic              neg_q;
    logic              in_ready_q;
    logic              out_valid_q;
`ifdef MUL_ITER_EARLY_OUT_EN
    logic [XLEN-1:0]   rem_q;
`endif

    logic              s1_signed_s;
    logic              s2_signed_s;
    logic [XLEN-1:0]   opa_s;
    logic [XLEN-1:0]   opb_s;
    logic [XLEN-1:0]   mag1_s;
    logic [XLEN-1:0]   mag2_s;
    logic              neg_s;
    logic [XLEN-1:0]   addend_s;
    logic [XLEN:0]     sum_s;
    logic [CNT_W-1:0]  iter_limit_s;
    logic              finish_s;
    logic [CNT_W-1:0]  shamt_s;
    logic [2*XLEN-1:0] prod_mag_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   result_s;

    function automatic logic [XLEN-1:0] sext_word(input logic [XLEN/2-1:0] w);
        return {{(XLEN/2){w[XLEN/2-1]}}, w};
    endfunction

    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
        return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [XLEN-1:0] select_result(input logic [3:0] op,
                                                      input logic [2*XLEN-1:0] prod);
        logic [XLEN-1:0] r;
        case (op)
            OP_MUL:                      r = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: r = prod[2*XLEN-1:XLEN];
            OP_MULW:                     r = sext_word(prod[XLEN/2-1:0]);
            default:                     r = X_ZERO;
        endcase
        return r;
    endfunction

    // Operand conditioning at accept: signedness per op, MULW word extension, magnitudes and result sign.
    always_comb begin
        s1_signed_s = 1'b0;
        s2_signed_s = 1'b0;
        case (control)
            OP_MUL, OP_MULH, OP_MULW: begin
                s1_signed_s = 1'b1;
                s2_signed_s = 1'b1;
            end
            OP_MULHSU: begin
                s1_signed_s = 1'b1;
                s2_signed_s = 1'b0;
            end
            default: begin
                s1_signed_s = 1'b0;
                s2_signed_s = 1'b0;
            end
        endcase

        if (control == OP_MULW) begin
            opa_s = sext_word(src1[XLEN/2-1:0]);
            opb_s = sext_word(src2[XLEN/2-1:0]);
        end else begin
            opa_s = src1;
            opb_s = src2;
        end

        // The magnitude of -2^63 is 2^63, which still fits as an unsigned 64-bit value.
        if (s1_signed_s && opa_s[XLEN-1]) begin
            mag1_s = neg_x(opa_s);
        end else begin
            mag1_s = opa_s;
        end
        if (s2_signed_s && opb_s[XLEN-1]) begin
            mag2_s = neg_x(opb_s);
        end else begin
            mag2_s = opb_s;
        end
        neg_s = (s1_signed_s & opa_s[XLEN-1]) ^ (s2_signed_s & opb_s[XLEN-1]);
    end

    // One shift-add step plus completion detection and final product assembly.
    always_comb begin
        if (mplier_q[0]) begin
            addend_s = mcand_q;
        end else begin
            addend_s = X_ZERO;
        end
        sum_s = {1'b0, acc_q} + {1'b0, addend_s};

        if (op_q == OP_MULW) begin
            iter_limit_s = ITER_WORD;
        end else begin
            iter_limit_s = ITER_FULL;
        end

        finish_s = (cnt_q == iter_limit_s);
`ifdef MUL_ITER_EARLY_OUT_EN
        if ((cnt_q != CNT_ZERO) && (rem_q == X_ZERO)) begin
            finish_s = 1'b1;
        end else begin
            finish_s = (cnt_q == iter_limit_s);
        end
`endif

        // Skipped iterations would only shift right, so the missing steps collapse into one shift.
        shamt_s    = ITER_FULL - cnt_q;
        prod_mag_s = {acc_q, mplier_q} >> shamt_s;
        if (neg_q) begin
            prod_s = neg_2x(prod_mag_s);
        end else begin
            prod_s = prod_mag_s;
        end
        result_s = select_result(op_q, prod_s);
    end

    // Control FSM with registered handshake outputs and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_ZERO;
            mcand_q     <= X_ZERO;
            acc_q       <= X_ZERO;
            mplier_q    <= X_ZERO;
            result_q    <= X_ZERO;
            op_q        <= 4'd0;
            neg_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef MUL_ITER_EARLY_OUT_EN
            rem_q       <= X_ZERO;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && !flush) begin
                        state_q    <= ST_BUSY;
                        in_ready_q <= 1'b0;
                        cnt_q      <= CNT_ZERO;
                        acc_q      <= X_ZERO;
                        mcand_q    <= mag1_s;
                        mplier_q   <= mag2_s;
                        neg_q      <= neg_s;
                        op_q       <= control;
`ifdef MUL_ITER_EARLY_OUT_EN
                        rem_q      <= mag2_s;
`endif
                    end
                end
                ST_BUSY: begin
                    if (flush) begin
                        state_q     <= ST_IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end else if (finish_s) begin
                        state_q     <= ST_DONE;
                        result_q    <= result_s;
                        out_valid_q <= 1'b1;
                    end else begin
                        acc_q    <= sum_s[XLEN:1];
                        mplier_q <= {sum_s[0], mplier_q[XLEN-1:1]};
                        cnt_q    <= cnt_q + CNT_ONE;
`ifdef MUL_ITER_EARLY_OUT_EN
                        rem_q    <= rem_q >> 1;
`endif
                    end
                end
                ST_DONE: begin
                    if (flush || out_ready) begin
                        state_q     <= ST_IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign result_out = result_q;

endmodule
